// File: rtl/s2p_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : s2p_frame_rx
// Brief    : Serial-to-parallel frame receiver. Deframes start/data/parity/
//            stop on the shared link clock, checks parity and framing, and
//            hands each good byte to the consumer over a valid/ack handshake.
// Revision : 1.0 - initial release
// ============================================================================
module s2p_frame_rx #(
  parameter int          DATA_W    = 8,
  parameter int unsigned PARITY_EN = 1
) (
  input  logic              ic_clk_ctrl,
  input  logic              reset,
  input  logic              S_data_in,
  input  logic              end_pass,
  input  logic              data_ack,
  output logic [DATA_W-1:0] P_data_out,
  output logic              data_valid,
  output logic              busy,
  output logic              parity_error,
  output logic              frame_error,
  output logic              overrun
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_DATA      = 3'd1,
    S_PARITY    = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_IDLE = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]    cnt_q,   cnt_d;
  logic                par_q,   par_d;
  logic [DATA_W-1:0]   data_q,  data_d;
  logic                valid_q, valid_d;
  logic                ovr_q,   ovr_d;
  logic                perr_q,  perr_d;
  logic                ferr_q,  ferr_d;
  logic                accept;

  // State, datapath and handshake registers; reset clears everything at once.
  always_ff @(posedge ic_clk_ctrl or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

  // Deframing FSM, stop-edge decision and consumer handshake.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    perr_d  = 1'b0;
    ferr_d  = 1'b0;
    accept  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!S_data_in) begin
          state_d = S_DATA;
          cnt_d   = CNT_W'(DATA_W - 1);
        end
      end
      S_DATA: begin
        // MSB arrives first, so each new bit enters at the LSB.
        shift_d    = shift_q << 1;
        shift_d[0] = S_data_in;
        if (cnt_q == '0) begin
          state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_PARITY: begin
        par_d   = S_data_in;
        state_d = S_STOP;
      end
      S_STOP: begin
        if (S_data_in) begin
          state_d = S_IDLE;
          if ((PARITY_EN != 0) && (par_q != ^shift_q)) begin
            perr_d = 1'b1;
          end else begin
            accept = 1'b1;
          end
        end else begin
          // Low stop bit: wait for the line to recover before hunting again.
          ferr_d  = 1'b1;
          state_d = S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        if (S_data_in) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort wins over everything the frame was about to do, silently.
    if (end_pass) begin
      state_d = S_IDLE;
      perr_d  = 1'b0;
      ferr_d  = 1'b0;
      accept  = 1'b0;
    end

    if (data_ack) begin
      ovr_d = 1'b0;
      if (valid_q) begin
        valid_d = 1'b0;
      end
    end

    // A new byte lands only if the holding register is free or being freed now.
    if (accept) begin
      if (!valid_q || data_ack) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  assign P_data_out   = data_q;
  assign data_valid   = valid_q;
  assign busy         = (state_q != S_IDLE);
  assign parity_error = perr_q;
  assign frame_error  = ferr_q;
  assign overrun      = ovr_q;

endmodule
`default_nettype wire
